ym2413_audio_post: RTL



---
 rtl/ym2413_audio_pkg.sv | 22 ++
 rtl/ym2413_dsm.sv | 28 ++
 rtl/ym2413_audio_post.sv | 93 +++++++++
 3 files changed

// File: rtl/ym2413_audio_pkg.sv
// Shared constants, types and helpers for the YM2413 audio post-processing stage.
package ym2413_audio_pkg;

    localparam int YM_MID  = 1024;
    localparam int APU_MID = 2048;
    localparam int PCM_MAX = 32767;
    localparam int PCM_MIN = -32768;
    localparam int LP_FRAC = 4;

    typedef logic signed [15:0] pcm_t;

    function automatic pcm_t sat_pcm(input logic signed [16:0] s);
        if (int'(s) > PCM_MAX) begin
            return pcm_t'(PCM_MAX);
        end
        if (int'(s) < PCM_MIN) begin
            return pcm_t'(PCM_MIN);
        end
        return pcm_t'(s);
    endfunction

endpackage

// File: rtl/ym2413_dsm.sv
// First-order delta-sigma modulator: offset-binary accumulator whose carry is the DAC bit.
module ym2413_dsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pcm_in,
    output logic        dac_out
);

    logic [15:0] acc_q;
    logic        dac_q;
    logic [16:0] sum_d;

    // Flipping the sign bit maps two's complement onto 0..65535 (midscale 32768).
    assign sum_d = {1'b0, acc_q} + {1'b0, pcm_in ^ 16'h8000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            dac_q <= 1'b0;
        end else begin
            acc_q <= sum_d[15:0];
            dac_q <= sum_d[16];
        end
    end

    assign dac_out = dac_q;

endmodule

// File: rtl/ym2413_audio_post.sv
// FM volume, one-pole low-pass, APU mix with saturation and delta-sigma output.
module ym2413_audio_post
    import ym2413_audio_pkg::*;
#(
    parameter int DIV = 32,
    parameter int K   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ym_in,
    input  logic [11:0] apu_in,
    input  logic [3:0]  vol,
    output logic [15:0] pcm_out,
    output logic        pcm_valid,
    output logic        dac_out
);

    logic [15:0]        div_cnt_q, div_cnt_d;
    logic               tick;
    logic [10:0]        ym_q;
    logic [11:0]        apu_q;
    logic [3:0]         vol_q;
    logic [2:0]         vld_q;
    logic signed [19:0] lp_q, lp_d;
    pcm_t               pcm_q, pcm_d;

    logic signed [11:0] ys;
    logic signed [16:0] prod;
    logic signed [15:0] x;
    logic signed [12:0] as_s;
    logic signed [16:0] a;
    logic signed [19:0] x20;
    logic signed [20:0] diff, step, lp_sum;
    logic signed [16:0] s;

    always_comb begin
        tick      = (div_cnt_q == 16'(DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + 16'd1;
    end

    assign ys   = $signed({1'b0, ym_q}) - 12'(YM_MID);
    assign prod = 17'(ys) * $signed({13'd0, vol_q});
    assign x    = 16'(prod <<< 1);
    assign as_s = $signed({1'b0, apu_q}) - 13'(APU_MID);
    assign a    = 17'(as_s) <<< 3;

    // 21-bit difference keeps x20 - lp from wrapping; >>> floors toward -inf.
    assign x20    = 20'(x) <<< LP_FRAC;
    assign diff   = 21'(x20) - 21'(lp_q);
    assign step   = diff >>> K;
    assign lp_sum = 21'(lp_q) + step;
    assign lp_d   = (K == 0) ? x20 : 20'(lp_sum);

    assign s     = 17'(lp_q >>> LP_FRAC) + a;
    assign pcm_d = sat_pcm(s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            vld_q     <= '0;
            ym_q      <= '0;
            apu_q     <= '0;
            vol_q     <= '0;
            lp_q      <= '0;
            pcm_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            vld_q     <= {vld_q[1:0], tick};
            if (tick) begin
                ym_q  <= ym_in;
                apu_q <= apu_in;
                vol_q <= vol;
            end
            if (vld_q[0]) begin
                lp_q <= lp_d;
            end
            if (vld_q[1]) begin
                pcm_q <= pcm_d;
            end
        end
    end

    assign pcm_out   = pcm_q;
    assign pcm_valid = vld_q[2];

    ym2413_dsm u_dsm (
        .clk     (clk),
        .reset   (reset),
        .pcm_in  (pcm_q),
        .dac_out (dac_out)
    );

endmodule
